// File: rtl/exec_ctrl_pkg.sv
// Shared widths, flag codes, FSM state type and jump-offset sign extension for exec_ctrl.
`ifndef EXEC_DEFINES
`define EXEC_DEFINES
`define A_BITS   10
`define D_BITS   16
`define FLAGS_NR 3
`define BLANK    3'd0
`define JUMP     3'd1
`define READ     3'd2
`define WRITE    3'd3
`define STOP     3'd4
`endif

package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    // Sign-extend the low 'bits' bits of raw to the full address width.
    function automatic logic [`A_BITS-1:0] sext_off(input logic [`A_BITS-1:0] raw,
                                                    input int bits);
        int sh;
        logic signed [`A_BITS-1:0] t;
        sh = `A_BITS - bits;
        t  = $signed(raw << sh);
        return $unsigned(t >>> sh);
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Memory request holder: latches one request, holds it until ack or timeout.
// done wins over timeout when both occur in the same cycle.
import exec_ctrl_pkg::*;

module mem_handshake #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                we,
    input  logic [`A_BITS-1:0]  addr,
    input  logic [`D_BITS-1:0]  wdata,
    input  logic                ack,
    output logic                req,
    output logic                req_we,
    output logic [`A_BITS-1:0]  req_addr,
    output logic [`D_BITS-1:0]  req_wdata,
    output logic                done,
    output logic                timeout
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign done    = req & ack;
    assign timeout = req & ~ack & (cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req       <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cnt       <= '0;
        end else if (start) begin
            req       <= 1'b1;
            req_we    <= we;
            req_addr  <= addr;
            req_wdata <= wdata;
            cnt       <= '0;
        end else if (req) begin
            if (done || timeout)
                req <= 1'b0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: memory handshake, stall/flush, PC redirect, write-back, halt.
// All outputs registered; one cycle from decision to output.
import exec_ctrl_pkg::*;

module exec_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 3,
    parameter int JMP_OFF_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid_i,
    input  logic [`FLAGS_NR-1:0] flags_alu_i,
    input  logic                 is_store_i,
    input  logic                 jump_rel_i,
    input  logic [`A_BITS-1:0]   ex_pc_i,
    input  logic [`D_BITS-1:0]   result_i,
    input  logic [`A_BITS-1:0]   addr_i,
    input  logic                 mem_ack_i,
    input  logic [`D_BITS-1:0]   mem_rdata_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [`A_BITS-1:0]   mem_addr_o,
    output logic [`D_BITS-1:0]   mem_wdata_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 pc_load_o,
    output logic [`A_BITS-1:0]   pc_target_o,
    output logic                 wb_valid_o,
    output logic [`D_BITS-1:0]   wb_data_o,
    output logic                 halted_o,
    output logic                 mem_err_o
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_t        state, state_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic          mem_start, mem_done, mem_timeout;

    logic               stall_nxt, flush_nxt, pc_load_nxt, wb_valid_nxt, halted_nxt, err_nxt;
    logic [`A_BITS-1:0] pc_target_nxt;
    logic [`D_BITS-1:0] wb_data_nxt;

    logic is_mem_op, is_reg_wb, is_jump, is_stop;

    assign is_mem_op = ex_valid_i && ((flags_alu_i == `READ) ||
                                      (flags_alu_i == `WRITE && is_store_i));
    assign is_reg_wb = ex_valid_i && flags_alu_i == `WRITE && !is_store_i;
    assign is_jump   = ex_valid_i && flags_alu_i == `JUMP;
    assign is_stop   = ex_valid_i && flags_alu_i == `STOP;

    mem_handshake #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mem_start),
        .we        (is_store_i),
        .addr      (addr_i),
        .wdata     (result_i),
        .ack       (mem_ack_i),
        .req       (mem_req_o),
        .req_we    (mem_we_o),
        .req_addr  (mem_addr_o),
        .req_wdata (mem_wdata_o),
        .done      (mem_done),
        .timeout   (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_cnt   <= '0;
            stall_o     <= 1'b0;
            flush_o     <= 1'b0;
            pc_load_o   <= 1'b0;
            pc_target_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_data_o   <= '0;
            halted_o    <= 1'b0;
            mem_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            stall_o     <= stall_nxt;
            flush_o     <= flush_nxt;
            pc_load_o   <= pc_load_nxt;
            pc_target_o <= pc_target_nxt;
            wb_valid_o  <= wb_valid_nxt;
            wb_data_o   <= wb_data_nxt;
            halted_o    <= halted_nxt;
            mem_err_o   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        mem_start     = 1'b0;
        unique case (state)
            RUN: begin
                if (is_mem_op) begin
                    mem_start = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (is_jump) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FW'(FLUSH_CYCLES - 1);
                end else if (is_stop) begin
                    state_nxt = HALTED;
                end
            end
            MEM_WAIT: begin
                if (mem_done)
                    state_nxt = RUN;
                else if (mem_timeout)
                    state_nxt = HALTED;
            end
            // flush_cnt counts the flush cycles still owed after the current one
            FLUSH: begin
                if (flush_cnt == '0)
                    state_nxt = RUN;
                else
                    flush_cnt_nxt = flush_cnt - FW'(1);
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        stall_nxt     = 1'b0;
        flush_nxt     = 1'b0;
        pc_load_nxt   = 1'b0;
        pc_target_nxt = pc_target_o;
        wb_valid_nxt  = 1'b0;
        wb_data_nxt   = wb_data_o;
        halted_nxt    = halted_o;
        err_nxt       = mem_err_o;
        unique case (state)
            RUN: begin
                if (is_mem_op) begin
                    stall_nxt = 1'b1;
                end else if (is_reg_wb) begin
                    wb_valid_nxt = 1'b1;
                    wb_data_nxt  = result_i;
                end else if (is_jump) begin
                    pc_load_nxt   = 1'b1;
                    flush_nxt     = 1'b1;
                    pc_target_nxt = jump_rel_i
                        ? ex_pc_i + sext_off(result_i[`A_BITS-1:0], JMP_OFF_BITS)
                        : result_i[`A_BITS-1:0];
                end else if (is_stop) begin
                    halted_nxt = 1'b1;
                    stall_nxt  = 1'b1;
                end
            end
            MEM_WAIT: begin
                stall_nxt = 1'b1;
                if (mem_done) begin
                    stall_nxt = 1'b0;
                    if (!mem_we_o) begin
                        wb_valid_nxt = 1'b1;
                        wb_data_nxt  = mem_rdata_i;
                    end
                end else if (mem_timeout) begin
                    err_nxt    = 1'b1;
                    halted_nxt = 1'b1;
                end
            end
            FLUSH: flush_nxt = (flush_cnt != '0);
            HALTED: begin
                stall_nxt  = 1'b1;
                halted_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
